// File: rtl/dff_share_arb.sv
// dff_share_arb: round-robin write arbiter for one shared DATA_W-bit register.
// Optional macro ARB_LOCK_EN compiles in bounded lock chaining (MAX_LOCK).
module dff_share_arb #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_LOCK = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*DATA_W-1:0] data_i,
    input  logic [NUM_REQ-1:0]        lock_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic [DATA_W-1:0]         q_o,
    output logic                      valid_o,
    output logic                      busy_o
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        ACK
    } state_t;

    state_t              state_q;
    logic [PW-1:0]       ptr_q;
    logic [PW-1:0]       win_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [NUM_REQ-1:0]  ack_q;
    logic [DATA_W-1:0]   q_q;
    logic                valid_q;

    logic [PW-1:0]       pick_d;
    logic                found_d;
    logic [PW-1:0]       idx_d;
    logic [PW-1:0]       win_nxt_d;
    logic [NUM_REQ-1:0]  pick_oh_d;
    logic [NUM_REQ-1:0]  win_oh_d;
    logic [DATA_W-1:0]   win_data_d;
    logic                win_req_d;

`ifdef ARB_LOCK_EN
    localparam int LW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK + 1) : 1;
    logic [LW-1:0]       lock_cnt_q;
    logic                relock_d;
`else
    logic                unused_lock;
    assign unused_lock = ^lock_i;
`endif

    // First set request at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        pick_d  = '0;
        found_d = 1'b0;
        idx_d   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(ptr_q) + i >= NUM_REQ) begin
                idx_d = PW'(int'(ptr_q) + i - NUM_REQ);
            end else begin
                idx_d = PW'(int'(ptr_q) + i);
            end
            if (!found_d && req_i[idx_d]) begin
                found_d = 1'b1;
                pick_d  = idx_d;
            end
        end
    end

    // Decode of the latched winner: next pointer, one-hot, request, data.
    always_comb begin
        win_nxt_d  = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
        pick_oh_d  = NUM_REQ'(1) << pick_d;
        win_oh_d   = NUM_REQ'(1) << win_q;
        win_req_d  = req_i[win_q];
        win_data_d = data_i[int'(win_q)*DATA_W +: DATA_W];
    end

`ifdef ARB_LOCK_EN
    // Locked winner may chain another write while under the lock budget.
    always_comb begin
        relock_d = lock_i[win_q] && win_req_d &&
                   (lock_cnt_q < LW'(MAX_LOCK - 1));
    end
`endif

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
`ifdef ARB_LOCK_EN
            lock_cnt_q <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
`ifdef ARB_LOCK_EN
                    lock_cnt_q <= '0;
`endif
                    if (found_d) begin
                        win_q   <= pick_d;
                        gnt_q   <= pick_oh_d;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    gnt_q <= '0;
                    if (win_req_d) begin
                        q_q     <= win_data_d;
                        ack_q   <= win_oh_d;
                        valid_q <= 1'b1;
                        state_q <= ACK;
                    end else begin
                        ptr_q   <= win_nxt_d;
                        state_q <= IDLE;
                    end
                end
                ACK: begin
                    ack_q <= '0;
`ifdef ARB_LOCK_EN
                    if (relock_d) begin
                        gnt_q      <= win_oh_d;
                        lock_cnt_q <= lock_cnt_q + 1'b1;
                        state_q    <= GRANT;
                    end else begin
                        ptr_q      <= win_nxt_d;
                        lock_cnt_q <= '0;
                        state_q    <= IDLE;
                    end
`else
                    ptr_q   <= win_nxt_d;
                    state_q <= IDLE;
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt_o   = gnt_q;
    assign ack_o   = ack_q;
    assign q_o     = q_q;
    assign valid_o = valid_q;
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_dff_share_arb.sv
// Directed bench for dff_share_arb (NUM_REQ=4, DATA_W=8, MAX_LOCK=4).
// Expectations follow the ARB_LOCK_EN setting of the build.
module tb_dff_share_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_i;
    logic [31:0] data_i;
    logic [3:0]  lock_i;
    logic [3:0]  gnt_o;
    logic [3:0]  ack_o;
    logic [7:0]  q_o;
    logic        valid_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    dff_share_arb #(
        .NUM_REQ (4),
        .DATA_W  (8),
        .MAX_LOCK(4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req_i  (req_i),
        .data_i (data_i),
        .lock_i (lock_i),
        .gnt_o  (gnt_o),
        .ack_o  (ack_o),
        .q_o    (q_o),
        .valid_o(valid_o),
        .busy_o (busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_i  = '0;
        lock_i = '0;
        data_i = '0;
        reset  = 1'b1;
        tick();
        reset  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({gnt_o, ack_o, q_o, valid_o, busy_o} !== 18'h0) begin
            errors++;
            $display("FAIL reset: gnt=%b ack=%b q=%h valid=%b busy=%b, need all 0",
                     gnt_o, ack_o, q_o, valid_o, busy_o);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        req_i  = 4'b0100;
        data_i = 32'h00A5_0000;
        tick();
        checks++;
        if (gnt_o !== 4'b0100 || ack_o !== 4'b0000 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: gnt=%b ack=%b busy=%b, need 0100 0000 1",
                     gnt_o, ack_o, busy_o);
        end
        tick();
        checks++;
        if (q_o !== 8'hA5 || ack_o !== 4'b0100 || valid_o !== 1'b1 || gnt_o !== 4'b0) begin
            errors++;
            $display("FAIL single_ack: q=%h ack=%b valid=%b gnt=%b, need a5 0100 1 0000",
                     q_o, ack_o, valid_o, gnt_o);
        end
        req_i = 4'b0000;
        tick();
        checks++;
        if (ack_o !== 4'b0000 || busy_o !== 1'b0 || valid_o !== 1'b1 || q_o !== 8'hA5) begin
            errors++;
            $display("FAIL single_done: ack=%b busy=%b valid=%b q=%h, need 0000 0 1 a5",
                     ack_o, busy_o, valid_o, q_o);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [7:0] exp_q [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        do_reset();
        req_i  = 4'b1111;
        data_i = 32'h1312_1110;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (gnt_o !== exp_g[i]) begin
                errors++;
                $display("FAIL rr_grant%0d: gnt=%b, need %b", i, gnt_o, exp_g[i]);
            end
            tick();
            checks++;
            if (q_o !== exp_q[i] || ack_o !== exp_g[i]) begin
                errors++;
                $display("FAIL rr_ack%0d: q=%h ack=%b, need %h %b",
                         i, q_o, ack_o, exp_q[i], exp_g[i]);
            end
            tick();
            checks++;
            if (busy_o !== 1'b0 || ack_o !== 4'b0) begin
                errors++;
                $display("FAIL rr_idle%0d: busy=%b ack=%b, need 0 0000", i, busy_o, ack_o);
            end
        end
    endtask

    task automatic test_abort();
        do_reset();
        req_i  = 4'b0011;
        data_i = 32'h0000_7766;
        tick();
        checks++;
        if (gnt_o !== 4'b0001) begin
            errors++;
            $display("FAIL abort_grant: gnt=%b, need 0001", gnt_o);
        end
        req_i = 4'b0010;
        tick();
        checks++;
        if (ack_o !== 4'b0 || q_o !== 8'h00 || valid_o !== 1'b0 ||
            busy_o !== 1'b0 || gnt_o !== 4'b0) begin
            errors++;
            $display("FAIL abort_drop: ack=%b q=%h valid=%b busy=%b gnt=%b, need 0 00 0 0 0",
                     ack_o, q_o, valid_o, busy_o, gnt_o);
        end
        tick();
        checks++;
        if (gnt_o !== 4'b0010) begin
            errors++;
            $display("FAIL abort_next: gnt=%b, need 0010", gnt_o);
        end
        tick();
        checks++;
        if (ack_o !== 4'b0010 || q_o !== 8'h77) begin
            errors++;
            $display("FAIL abort_write: ack=%b q=%h, need 0010 77", ack_o, q_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_i  = 4'b0001;
        data_i = 32'h0000_003C;
        tick();
        tick();
        req_i = 4'b0000;
        tick();
        req_i  = 4'b0001;
        data_i = 32'h0000_0055;
        tick();
        checks++;
        if (gnt_o !== 4'b0001 || q_o !== 8'h3C) begin
            errors++;
            $display("FAIL midrst_setup: gnt=%b q=%h, need 0001 3c", gnt_o, q_o);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({gnt_o, ack_o, q_o, valid_o, busy_o} !== 18'h0) begin
            errors++;
            $display("FAIL midrst_clear: gnt=%b ack=%b q=%h valid=%b busy=%b, need all 0",
                     gnt_o, ack_o, q_o, valid_o, busy_o);
        end
        reset = 1'b0;
        req_i = 4'b0000;
        tick();
        checks++;
        if (ack_o !== 4'b0 || q_o !== 8'h00 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_noack: ack=%b q=%h valid=%b, need 0 00 0",
                     ack_o, q_o, valid_o);
        end
    endtask

    task automatic test_lock();
        do_reset();
        req_i  = 4'b0110;
        lock_i = 4'b0010;
        data_i = 32'h0000_B100;
`ifdef ARB_LOCK_EN
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (gnt_o !== 4'b0010 || ack_o !== 4'b0) begin
                errors++;
                $display("FAIL lock_grant%0d: gnt=%b ack=%b, need 0010 0000", i, gnt_o, ack_o);
            end
            tick();
            checks++;
            if (ack_o !== 4'b0010 || q_o !== 8'hB1) begin
                errors++;
                $display("FAIL lock_ack%0d: ack=%b q=%h, need 0010 b1", i, ack_o, q_o);
            end
        end
        tick();
        checks++;
        if (gnt_o !== 4'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL lock_release: gnt=%b busy=%b, need 0000 0", gnt_o, busy_o);
        end
        tick();
        checks++;
        if (gnt_o !== 4'b0100) begin
            errors++;
            $display("FAIL lock_next: gnt=%b, need 0100", gnt_o);
        end
`else
        tick();
        checks++;
        if (gnt_o !== 4'b0010) begin
            errors++;
            $display("FAIL nolock_grant1: gnt=%b, need 0010", gnt_o);
        end
        tick();
        checks++;
        if (ack_o !== 4'b0010 || q_o !== 8'hB1) begin
            errors++;
            $display("FAIL nolock_ack1: ack=%b q=%h, need 0010 b1", ack_o, q_o);
        end
        tick();
        checks++;
        if (gnt_o !== 4'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL nolock_idle: gnt=%b busy=%b, need 0000 0", gnt_o, busy_o);
        end
        tick();
        checks++;
        if (gnt_o !== 4'b0100) begin
            errors++;
            $display("FAIL nolock_grant2: gnt=%b, need 0100", gnt_o);
        end
`endif
    endtask

    initial begin
        reset  = 1'b1;
        req_i  = '0;
        lock_i = '0;
        data_i = '0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_abort();
        test_reset_mid();
        test_lock();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dff_share_arb.md
# dff_share_arb

Round-robin arbiter that shares a single DATA_W-bit storage register (D flip-flop bank) between NUM_REQ requesters. It grants one requester at a time, loads that requester's data into the shared register, and returns a one-cycle acknowledge. It sits in front of the shared flop bank as that bank's only write controller; every requester reads the stored value from q_o.

## Interface
- NUM_REQ, default 4: number of requesters (2..8).
- DATA_W, default 8: width of the shared register.
- MAX_LOCK, default 4: maximum consecutive writes by one locked requester. Only used with ARB_LOCK_EN.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req_i  input  NUM_REQ  per-requester write request, level.
- data_i  input  NUM_REQ*DATA_W  write data; slice k is [k*DATA_W +: DATA_W].
- lock_i  input  NUM_REQ  per-requester lock request. The port is always present; it is ignored without ARB_LOCK_EN.
- gnt_o  output  NUM_REQ  one-hot grant, registered.
- ack_o  output  NUM_REQ  one-hot write-done pulse, registered, 1 cycle.
- q_o  output  DATA_W  shared register contents.
- valid_o  output  1  high once the first write completes; stays high until reset.
- busy_o  output  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, GRANT, ACK. A round-robin pointer ptr (clog2(NUM_REQ) bits) holds the highest-priority index.
- IDLE: if req_i is non-zero, the winner is the first set bit searching from ptr upward, wrapping modulo NUM_REQ.
  - The winner index is latched.
  - gnt_o is set to the winner's one-hot value.
  - Next state is GRANT.
  - If req_i is zero, the FSM stays in IDLE.
- GRANT:
  - If req_i[winner] is still 1: q_o <= data_i slice of the winner, sampled this cycle; ack_o is set to the winner's one-hot value; valid_o <= 1; gnt_o clears; next state is ACK.
  - If req_i[winner] has dropped (abort): no write, no ack; gnt_o clears; ptr <= winner+1 mod NUM_REQ; next state is IDLE.
- ACK:
  - ack_o clears.
  - Default: ptr <= winner+1 mod NUM_REQ; next state is IDLE.
  - With ARB_LOCK_EN, if lock_i[winner] and req_i[winner] are both 1 and lock_cnt < MAX_LOCK-1: gnt_o is set to the winner again; lock_cnt increments; ptr is unchanged; next state is GRANT.
- Requesters hold req_i and their data_i slice stable while gnt_o for them is high. Requests from other requesters are ignored until the next IDLE.
- Simultaneous requests are resolved purely by ptr. Every continuously requesting requester is served within NUM_REQ writes (NUM_REQ*MAX_LOCK writes with locking).
- lock_cnt resets to 0 on every entry to IDLE.

## Timing
- Reset values (one edge after reset=1): state IDLE, ptr 0, gnt_o 0, ack_o 0, q_o 0, valid_o 0, busy_o 0, lock_cnt 0.
- Reset dominates every other condition, including mid-GRANT or mid-ACK. An in-flight write is discarded and no ack is issued.
- Take req_i rising before edge E while in IDLE. Then:
  - gnt_o is valid after E.
  - q_o and ack_o are valid after E+1.
  - ack_o drops and the FSM is back in IDLE after E+2.
- Non-locked throughput is one write per 3 cycles. Locked chaining is one write per 2 cycles.
- q_o changes only on the GRANT->ACK edge. ack_o high means q_o already holds the acknowledged data.
- Pointer wrap: winner NUM_REQ-1 gives ptr 0.

## Configuration
- ARB_LOCK_EN defined: the lock behaviour in ACK is compiled in, bounded by MAX_LOCK consecutive writes.
- ARB_LOCK_EN undefined: lock_i is unused and lock_cnt is absent. ACK always returns to IDLE and advances ptr (strict round-robin).

## Test plan
- Single write, after reset: req_i=4'b0100 and slice2=8'hA5 at cycle 0 -> gnt_o=0100 after edge 1; q_o=8'hA5, ack_o=0100 and valid_o=1 after edge 2; ack_o=0 and busy_o=0 after edge 3.
- Round-robin rotation: req_i=4'b1111 held, slice k = 8'h10+k -> grant order 0001, 0010, 0100, 1000, 0001, one grant every 3 cycles; q_o sequence 10, 11, 12, 13, 10.
- Abort: req_i=4'b0011; drop req_i[0] during GRANT for requester 0 -> no ack_o, q_o unchanged; next grant is 0010.
- Reset mid-operation: reset=1 while in GRANT with q_o=8'h3C -> after the edge, gnt_o=0, ack_o=0, q_o=8'h00, valid_o=0; no ack ever issued for that write.
- Lock (ARB_LOCK_EN, MAX_LOCK=4): req_i=4'b0110, lock_i=4'b0010 -> 4 consecutive writes by requester 1, 2 cycles apart, then grant 0100. Without the macro the grants alternate 0010, 0100.
